// File: rtl/csu_dac_ctrl.sv
// Current source unit DAC sequencer: power-up/settle, segmented code decode, ramped thermometer, power-down.
// Optional behavioural current monitor output i_mon enabled by macro CSU_DAC_CTRL_IMON_EN.
module csu_dac_ctrl #(
    parameter int  SETTLE_CYC = 16,
    parameter int  THERM_MAX  = 17,
    parameter real IREF_A     = 500e-6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [10:0]          code_in,
    input  logic                 code_valid,
    output logic                 code_ready,
    input  logic                 red_en,
    input  logic [1:0]           atb_sel,
    input  logic                 atb_wr,
    output logic                 pdb,
    output logic [THERM_MAX-1:0] therm_en,
    output logic [5:0]           bin_en,
    output logic                 bin_red_en,
    output logic [1:0]           atb_ena,
    output logic                 busy,
    output logic                 clamp_err
`ifdef CSU_DAC_CTRL_IMON_EN
    ,
    output real                  i_mon
`endif
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_PWRUP = 3'd1;
    localparam logic [2:0] ST_IDLE  = 3'd2;
    localparam logic [2:0] ST_RAMP  = 3'd3;
    localparam logic [2:0] ST_PWRDN = 3'd4;

    localparam int              SC_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
    localparam logic [4:0]      THERM_MAX_C = 5'(THERM_MAX);

    function automatic logic [THERM_MAX-1:0] therm_decode(input logic [4:0] cnt);
        logic [THERM_MAX-1:0] v;
        for (int i = 0; i < THERM_MAX; i++) begin
            v[i] = (5'(i) < cnt);
        end
        return v;
    endfunction

    logic [2:0]           state_r;
    logic [4:0]           therm_cnt_r;
    logic [4:0]           target_r;
    logic [5:0]           bin_target_r;
    logic [SC_W-1:0]      settle_r;
    logic [1:0]           atb_r;
    logic                 pdb_r;
    logic [THERM_MAX-1:0] therm_en_r;
    logic [5:0]           bin_en_r;
    logic                 bin_red_en_r;
    logic [1:0]           atb_ena_r;
    logic                 code_ready_r;
    logic                 busy_r;
    logic                 clamp_err_r;

    logic [2:0]           state_nxt_s;
    logic [4:0]           therm_cnt_nxt_s;
    logic [4:0]           target_nxt_s;
    logic [5:0]           bin_target_nxt_s;
    logic [SC_W-1:0]      settle_nxt_s;
    logic [1:0]           atb_nxt_s;
    logic                 pdb_nxt_s;
    logic [5:0]           bin_en_nxt_s;
    logic                 clamp_nxt_s;
    logic [4:0]           therm_field_s;
    logic                 clamped_s;

    assign therm_field_s = code_in[10:6];
    assign clamped_s     = (therm_field_s > THERM_MAX_C);

    // Sequencer next-state and datapath update.
    always_comb begin
        state_nxt_s      = state_r;
        therm_cnt_nxt_s  = therm_cnt_r;
        target_nxt_s     = target_r;
        bin_target_nxt_s = bin_target_r;
        settle_nxt_s     = settle_r;
        pdb_nxt_s        = pdb_r;
        bin_en_nxt_s     = bin_en_r;
        clamp_nxt_s      = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (en) begin
                    state_nxt_s  = ST_PWRUP;
                    pdb_nxt_s    = 1'b1;
                    settle_nxt_s = {SC_W{1'b0}};
                end else begin
                    pdb_nxt_s    = 1'b0;
                end
            end
            ST_PWRUP: begin
                if (!en) begin
                    state_nxt_s  = ST_OFF;
                    pdb_nxt_s    = 1'b0;
                end else if (settle_r == SETTLE_LAST) begin
                    state_nxt_s  = ST_IDLE;
                end else begin
                    settle_nxt_s = settle_r + {{(SC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                // Power-down request takes precedence over a pending code.
                if (!en) begin
                    state_nxt_s      = ST_PWRDN;
                    bin_en_nxt_s     = 6'd0;
                end else if (code_valid) begin
                    state_nxt_s      = ST_RAMP;
                    target_nxt_s     = clamped_s ? THERM_MAX_C : therm_field_s;
                    bin_target_nxt_s = code_in[5:0];
                    clamp_nxt_s      = clamped_s;
                end else begin
                    state_nxt_s      = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (!en) begin
                    state_nxt_s     = ST_PWRDN;
                    bin_en_nxt_s    = 6'd0;
                end else if (therm_cnt_r < target_r) begin
                    therm_cnt_nxt_s = therm_cnt_r + 5'd1;
                end else if (therm_cnt_r > target_r) begin
                    therm_cnt_nxt_s = therm_cnt_r - 5'd1;
                end else begin
                    bin_en_nxt_s    = bin_target_r;
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_PWRDN: begin
                bin_en_nxt_s = 6'd0;
                // pdb drops on the same edge the last cell turns off.
                if (therm_cnt_r <= 5'd1) begin
                    therm_cnt_nxt_s = 5'd0;
                    pdb_nxt_s       = 1'b0;
                    state_nxt_s     = ST_OFF;
                end else begin
                    therm_cnt_nxt_s = therm_cnt_r - 5'd1;
                end
            end
            default: begin
                state_nxt_s     = ST_OFF;
                pdb_nxt_s       = 1'b0;
                therm_cnt_nxt_s = 5'd0;
                bin_en_nxt_s    = 6'd0;
            end
        endcase
    end

    // Testbus register write, locked out while powered off.
    always_comb begin
        if (atb_wr && (state_r != ST_OFF)) begin
            atb_nxt_s = atb_sel;
        end else begin
            atb_nxt_s = atb_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_OFF;
            therm_cnt_r  <= 5'd0;
            target_r     <= 5'd0;
            bin_target_r <= 6'd0;
            settle_r     <= {SC_W{1'b0}};
            atb_r        <= 2'b00;
            pdb_r        <= 1'b0;
            therm_en_r   <= {THERM_MAX{1'b0}};
            bin_en_r     <= 6'd0;
            bin_red_en_r <= 1'b0;
            atb_ena_r    <= 2'b00;
            code_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            clamp_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            therm_cnt_r  <= therm_cnt_nxt_s;
            target_r     <= target_nxt_s;
            bin_target_r <= bin_target_nxt_s;
            settle_r     <= settle_nxt_s;
            atb_r        <= atb_nxt_s;
            pdb_r        <= pdb_nxt_s;
            therm_en_r   <= therm_decode(therm_cnt_nxt_s);
            bin_en_r     <= bin_en_nxt_s;
            bin_red_en_r <= red_en & pdb_r;
            atb_ena_r    <= (state_nxt_s != ST_OFF) ? atb_nxt_s : 2'b00;
            code_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r       <= (state_nxt_s == ST_PWRUP) || (state_nxt_s == ST_RAMP) ||
                            (state_nxt_s == ST_PWRDN);
            clamp_err_r  <= clamp_nxt_s;
        end
    end

    assign code_ready = code_ready_r;
    assign pdb        = pdb_r;
    assign therm_en   = therm_en_r;
    assign bin_en     = bin_en_r;
    assign bin_red_en = bin_red_en_r;
    assign atb_ena    = atb_ena_r;
    assign busy       = busy_r;
    assign clamp_err  = clamp_err_r;

`ifdef CSU_DAC_CTRL_IMON_EN
    real imon_acc_s;

    // Behavioural sum of unit, binary and redundant cell currents.
    always_comb begin
        imon_acc_s = real'(therm_cnt_r) * IREF_A / 2.5;
        for (int k = 0; k < 6; k++) begin
            if (bin_en_r[k]) begin
                imon_acc_s = imon_acc_s + IREF_A / (2.5 * real'(1 << (6 - k)));
            end else begin
                imon_acc_s = imon_acc_s + 0.0;
            end
        end
        if (bin_red_en_r) begin
            imon_acc_s = imon_acc_s + IREF_A / 160.0;
        end else begin
            imon_acc_s = imon_acc_s + 0.0;
        end
        i_mon = pdb_r ? imon_acc_s : 0.0;
    end
`endif

endmodule

// File: tb/tb_csu_dac_ctrl.sv
// Directed table-driven bench for csu_dac_ctrl with SETTLE_CYC=16, THERM_MAX=17.
module tb_csu_dac_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] code_in;
    logic        code_valid;
    logic        code_ready;
    logic        red_en;
    logic [1:0]  atb_sel;
    logic        atb_wr;
    logic        pdb;
    logic [16:0] therm_en;
    logic [5:0]  bin_en;
    logic        bin_red_en;
    logic [1:0]  atb_ena;
    logic        busy;
    logic        clamp_err;
`ifdef CSU_DAC_CTRL_IMON_EN
    real         i_mon;
`endif

    int checks = 0;
    int errors = 0;

    csu_dac_ctrl #(.SETTLE_CYC(16), .THERM_MAX(17), .IREF_A(500e-6)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .red_en     (red_en),
        .atb_sel    (atb_sel),
        .atb_wr     (atb_wr),
        .pdb        (pdb),
        .therm_en   (therm_en),
        .bin_en     (bin_en),
        .bin_red_en (bin_red_en),
        .atb_ena    (atb_ena),
        .busy       (busy),
        .clamp_err  (clamp_err)
`ifdef CSU_DAC_CTRL_IMON_EN
        ,
        .i_mon      (i_mon)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;     int en;   int vld;  int code; int awr;   int asel;
        int pdb;   int rdy;  int therm; int bin; int busy;  int clamp;
        int atb;   int bred;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, int e, int v, int c, int aw, int as,
                                int p, int r, int t, int b, int bs, int cl,
                                int at, int br);
        vec_t x;
        x = '{n, e, v, c, aw, as, p, r, t, b, bs, cl, at, br};
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input int p, input int r, input int t, input int b,
                           input int bs, input int cl, input int at, input int br);
        chk("pdb",        idx, int'(pdb),        p);
        chk("code_ready", idx, int'(code_ready), r);
        chk("therm_en",   idx, int'(therm_en),   t);
        chk("bin_en",     idx, int'(bin_en),     b);
        chk("busy",       idx, int'(busy),       bs);
        chk("clamp_err",  idx, int'(clamp_err),  cl);
        chk("atb_ena",    idx, int'(atb_ena),    at);
        chk("bin_red_en", idx, int'(bin_red_en), br);
    endtask

    task automatic drive(input int e, input int v, input int c, input int aw, input int as);
        en         = 1'(e);
        code_valid = 1'(v);
        code_in    = 11'(c);
        atb_wr     = 1'(aw);
        atb_sel    = 2'(as);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //   n  en vld code    awr asel | pdb rdy therm    bin   busy clamp atb bred
        add( 1, 1, 0, 11'h000, 0, 0,     1,  0,  'h00000, 'h00, 1,   0,    0,  0);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  0,  'h00000, 'h00, 1,   0,    0,  1);
        add(14, 1, 0, 11'h000, 0, 0,     1,  0,  'h00000, 'h00, 1,   0,    0,  1);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  1,  'h00000, 'h00, 0,   0,    0,  1);
        add( 1, 1, 0, 11'h000, 1, 2,     1,  1,  'h00000, 'h00, 0,   0,    2,  1);
        add( 1, 1, 1, 11'h2A5, 0, 0,     1,  0,  'h00000, 'h00, 1,   0,    2,  1);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  0,  'h00001, 'h00, 1,   0,    2,  1);
        add( 9, 1, 0, 11'h000, 0, 0,     1,  0,  'h003FF, 'h00, 1,   0,    2,  1);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  1,  'h003FF, 'h25, 0,   0,    2,  1);
        add( 1, 1, 1, 11'h7C3, 0, 0,     1,  0,  'h003FF, 'h25, 1,   1,    2,  1);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  0,  'h007FF, 'h25, 1,   0,    2,  1);
        add( 6, 1, 0, 11'h000, 0, 0,     1,  0,  'h1FFFF, 'h25, 1,   0,    2,  1);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  1,  'h1FFFF, 'h03, 0,   0,    2,  1);
        add( 2, 1, 0, 11'h000, 0, 0,     1,  1,  'h1FFFF, 'h03, 0,   0,    2,  1);
        add( 1, 1, 1, 11'h7C3, 0, 0,     1,  0,  'h1FFFF, 'h03, 1,   1,    2,  1);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  1,  'h1FFFF, 'h03, 0,   0,    2,  1);
        add( 1, 1, 1, 11'h03F, 0, 0,     1,  0,  'h1FFFF, 'h03, 1,   0,    2,  1);
        add(17, 1, 0, 11'h000, 0, 0,     1,  0,  'h00000, 'h03, 1,   0,    2,  1);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  1,  'h00000, 'h3F, 0,   0,    2,  1);
        add( 1, 1, 1, 11'h2A5, 0, 0,     1,  0,  'h00000, 'h3F, 1,   0,    2,  1);
        add( 5, 1, 0, 11'h000, 0, 0,     1,  0,  'h0001F, 'h3F, 1,   0,    2,  1);
        add( 1, 0, 0, 11'h000, 0, 0,     1,  0,  'h0001F, 'h00, 1,   0,    2,  1);
        add( 4, 1, 0, 11'h000, 0, 0,     1,  0,  'h00001, 'h00, 1,   0,    2,  1);
        add( 1, 0, 0, 11'h000, 0, 0,     0,  0,  'h00000, 'h00, 0,   0,    0,  1);
        add( 1, 0, 0, 11'h000, 0, 0,     0,  0,  'h00000, 'h00, 0,   0,    0,  0);
        add( 1, 0, 0, 11'h000, 1, 1,     0,  0,  'h00000, 'h00, 0,   0,    0,  0);
        add( 1, 1, 0, 11'h000, 0, 0,     1,  0,  'h00000, 'h00, 1,   0,    2,  0);
        add(16, 1, 0, 11'h000, 0, 0,     1,  1,  'h00000, 'h00, 0,   0,    2,  1);
        add( 1, 1, 1, 11'h200, 0, 0,     1,  0,  'h00000, 'h00, 1,   0,    2,  1);
        add( 8, 1, 0, 11'h000, 0, 0,     1,  0,  'h000FF, 'h00, 1,   0,    2,  1);

        red_en = 1'b1;
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk_all(-1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].vld, vecs[i].code, vecs[i].awr, vecs[i].asel);
            step(vecs[i].n);
            chk_all(i, vecs[i].pdb, vecs[i].rdy, vecs[i].therm, vecs[i].bin,
                    vecs[i].busy, vecs[i].clamp, vecs[i].atb, vecs[i].bred);
        end

        // Reset in the middle of a ramp at therm_cnt=8 clears everything.
        drive(1, 0, 0, 0, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_all(100, 0, 0, 0, 0, 0, 0, 0, 0);

        // Power-up aborted by en=0 returns to OFF without waiting.
        step(1);
        chk_all(101, 1, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        step(1);
        chk_all(102, 0, 0, 0, 0, 0, 0, 0, 1);

        // Full settle count after a fresh power-up.
        drive(1, 0, 0, 0, 0);
        step(1);
        chk_all(103, 1, 0, 0, 0, 1, 0, 0, 0);
        step(15);
        chk_all(104, 1, 0, 0, 0, 1, 0, 0, 1);
        step(1);
        chk_all(105, 1, 1, 0, 0, 0, 0, 0, 1);

        // en=0 coinciding with code_valid: code is dropped, no clamp pulse.
        drive(0, 1, 11'h7C3, 0, 0);
        step(1);
        chk_all(106, 1, 0, 0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        step(1);
        chk_all(107, 0, 0, 0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
